// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the async instruction memory and
// buffers {pc, word} in a small FIFO for decode. Option macro: JMP_PREDECODE_EN.
module fetch_unit #(
  parameter int          QDEPTH   = 2,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [7:0]  out_pc,
  output logic [3:0]  q_count
);

  localparam int         PW     = $clog2(QDEPTH);
  localparam logic [3:0] DEPTH4 = 4'(QDEPTH);

  logic [7:0]    pc_q, pc_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [7:0]    qpc_q    [QDEPTH];
  logic [15:0]   qinstr_q [QDEPTH];

  logic full;
  logic pop;
  logic push;

  // Handshake: decode takes the head on a cycle where out_valid and out_ready
  // are both high; out_valid never depends on out_ready.
  assign out_valid = (count_q != 4'd0);
  assign full      = (count_q == DEPTH4);
  assign pop       = out_valid & out_ready;
  assign push      = fetch_en & ~redirect_valid & (~full | pop);

  assign imem_addr = pc_q;
  assign q_count   = count_q;
  assign out_instr = out_valid ? qinstr_q[rd_q] : 16'h0000;
  assign out_pc    = out_valid ? qpc_q[rd_q]    : 8'h00;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (redirect_valid) begin
      // Flush wins over any concurrent pop; pointers restart together.
      pc_d    = redirect_pc;
      count_d = 4'd0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 8'd1;
`ifdef JMP_PREDECODE_EN
        if (imem_data[15:12] == 4'b0101) begin
          pc_d = imem_data[7:0];
        end
`endif
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 4'd1;
      end else if (pop && !push) begin
        count_d = count_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= 4'd0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[wr_q]    <= pc_q;
      qinstr_q[wr_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, full+pop, redirect
// flush, PC wrap, JMP predecode and asynchronous reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic [3:0]  q_count;

  logic [15:0] mem [256];
  int tests;
  int fails;
  logic [7:0] jmp_next;

  fetch_unit #(.QDEPTH(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .q_count(q_count)
  );

  assign imem_data = mem[imem_addr];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] word_at(input logic [7:0] a);
    if (a == 8'h07) return 16'h5000;
    return {8'hC3, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic v, input logic [7:0] pc,
                             input logic [3:0] cnt, input logic [7:0] addr);
    check({tag, ".valid"}, 16'(out_valid), 16'(v));
    check({tag, ".pc"},    16'(out_pc),    v ? 16'(pc) : 16'h0000);
    check({tag, ".instr"}, out_instr,      v ? word_at(pc) : 16'h0000);
    check({tag, ".count"}, 16'(q_count),   16'(cnt));
    check({tag, ".addr"},  16'(imem_addr), 16'(addr));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 256; i++) mem[i] = word_at(8'(i));
`ifdef JMP_PREDECODE_EN
    jmp_next = 8'h00;
`else
    jmp_next = 8'h08;
`endif
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    check_state("reset", 1'b0, 8'h00, 4'd0, 8'h00);

    // Streaming from reset release: one instruction per cycle.
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    tick(); check_state("stream0", 1'b1, 8'h00, 4'd1, 8'h01);
    tick(); check_state("stream1", 1'b1, 8'h01, 4'd1, 8'h02);
    tick(); check_state("stream2", 1'b1, 8'h02, 4'd1, 8'h03);
    tick(); check_state("stream3", 1'b1, 8'h03, 4'd1, 8'h04);

    // Asynchronous reset mid-operation, seen before any clock edge.
    rst = 1'b1;
    #1;
    check_state("async_rst", 1'b0, 8'h00, 4'd0, 8'h00);

    // Backpressure: five cycles with out_ready low.
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); check_state("bp1", 1'b1, 8'h00, 4'd1, 8'h01);
    tick(); check_state("bp2", 1'b1, 8'h00, 4'd2, 8'h02);
    tick(); tick(); tick();
    check_state("bp_hold", 1'b1, 8'h00, 4'd2, 8'h02);

    // Full with a pop: push and pop together, count unchanged.
    out_ready = 1'b1;
    tick(); check_state("full_pop", 1'b1, 8'h01, 4'd2, 8'h03);
    tick(); check_state("drain2", 1'b1, 8'h02, 4'd2, 8'h04);

    // Redirect flushes the queue and discards the concurrent pop.
    redirect_valid = 1'b1; redirect_pc = 8'h05;
    tick(); check_state("redir_flush", 1'b0, 8'h00, 4'd0, 8'h05);
    redirect_valid = 1'b0;
    tick(); check_state("redir_tgt", 1'b1, 8'h05, 4'd1, 8'h06);
    tick(); check_state("after6", 1'b1, 8'h06, 4'd1, 8'h07);
    tick(); check_state("jmp_push", 1'b1, 8'h07, 4'd1, jmp_next);
    tick(); check_state("jmp_next", 1'b1, jmp_next, 4'd1, jmp_next + 8'd1);

    // fetch_en low: PC frozen, queue drains, out_ready ignored when empty.
    fetch_en = 1'b0;
    tick(); check_state("fe_off", 1'b0, 8'h00, 4'd0, jmp_next + 8'd1);
    tick(); check_state("empty_hold", 1'b0, 8'h00, 4'd0, jmp_next + 8'd1);

    // PC wrap from 8'hFF to 8'h00.
    fetch_en = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    tick(); check_state("wrap_redir", 1'b0, 8'h00, 4'd0, 8'hFF);
    redirect_valid = 1'b0;
    tick(); check_state("wrap_ff", 1'b1, 8'hFF, 4'd1, 8'h00);
    tick(); check_state("wrap_00", 1'b1, 8'hFF, 4'd2, 8'h01);
    out_ready = 1'b1;
    tick(); check_state("wrap_pop", 1'b1, 8'h00, 4'd2, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
